// File: rtl/serial_mag_comp_pkg.sv
// Types shared by the serial magnitude comparator.
package serial_mag_comp_pkg;

`include "comp_defs.vh"

    typedef enum logic [1:0] {
        IDLE = `COMP_ST_IDLE,
        SCAN = `COMP_ST_SCAN,
        DONE = `COMP_ST_DONE
    } state_t;

endpackage

// File: rtl/comp_defs.vh
// Shared state encodings for the serial magnitude comparator FSM.
`ifndef COMP_DEFS_VH
`define COMP_DEFS_VH

`define COMP_ST_IDLE 2'd0
`define COMP_ST_SCAN 2'd1
`define COMP_ST_DONE 2'd2

`endif

// File: rtl/serial_mag_comp_bit_cmp_cell.sv
// Single bit-pair compare cell: flags a difference and which side is larger.
module bit_cmp_cell (
    input  logic x,
    input  logic y,
    output logic diff,
    output logic x_gt
);

    assign diff = x ^ y;
    assign x_gt = x & ~y;

endmodule

// File: rtl/serial_mag_comp.sv
// Serial unsigned magnitude comparator: scans operands MSB first, one bit
// per cycle, stopping at the first differing bit.
module serial_mag_comp
    import serial_mag_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       eq,
    output logic                       gt,
    output logic                       lt,
    output logic [$clog2(WIDTH+1)-1:0] nscan
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [IW-1:0]    idx_reg;
    logic [CW-1:0]    cnt_reg;
    logic             eq_reg;
    logic             gt_reg;
    logic             lt_reg;
    logic [CW-1:0]    nscan_reg;

    logic bit_diff;
    logic bit_x_gt;
    logic scan_end;

    // The MSB of each shift register is the bit pair under test this cycle.
    bit_cmp_cell u_cell (
        .x    (a_sh_reg[WIDTH-1]),
        .y    (b_sh_reg[WIDTH-1]),
        .diff (bit_diff),
        .x_gt (bit_x_gt)
    );

    // Scan finishes on the first difference or after the last bit.
    assign scan_end = bit_diff || (idx_reg == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (scan_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shifting, and result registers that only
    // change when a scan completes so they hold through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            eq_reg    <= 1'b0;
            gt_reg    <= 1'b0;
            lt_reg    <= 1'b0;
            nscan_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg <= a;
                        b_sh_reg <= b;
                        idx_reg  <= IW'(WIDTH - 1);
                        cnt_reg  <= '0;
                    end
                end
                SCAN: begin
                    a_sh_reg <= a_sh_reg << 1;
                    b_sh_reg <= b_sh_reg << 1;
                    idx_reg  <= idx_reg - 1'b1;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (scan_end) begin
                        eq_reg    <= ~bit_diff;
                        gt_reg    <= bit_x_gt;
                        lt_reg    <= bit_diff & ~bit_x_gt;
                        nscan_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE);
    assign eq    = eq_reg;
    assign gt    = gt_reg;
    assign lt    = lt_reg;
    assign nscan = nscan_reg;

endmodule
